uart_i2c_sequencer: RTL

Control stage between the UART core's RX FIFO and the I2C master controller. It replaces manual button triggering: it pops each received byte, issues one I2C write of that byte to a fixed slave address, and waits for the master to finish. On success it optionally echoes the byte back through the UART TX FIFO. A watchdog flags a master that never starts or never finishes.

---
 rtl/uart_i2c_sequencer_pkg.sv | 19 +
 rtl/uart_i2c_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_i2c_sequencer_pkg.sv
// Shared definitions for the UART-to-I2C byte sequencer.
package uart_i2c_sequencer_pkg;

    // Sequencer states, in the order a byte moves through them.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ECHO      = 3'd4
    } state_t;

    // Width of the saturating watchdog timer.
    localparam int TIMER_W = 20;

    // I2C R/W bit value for a write transaction.
    localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/uart_i2c_sequencer.sv
// Pops bytes from the UART RX FIFO, writes each to a fixed I2C slave,
// waits for the master to finish and optionally echoes the byte to UART TX.
// A saturating watchdog flags a master that never starts or never finishes.
module uart_i2c_sequencer
    import uart_i2c_sequencer_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR     = 7'h2A,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter bit         ECHO_EN        = 1'b1
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        read_uart,
    input  logic        tx_full,
    output logic        write_uart,
    output logic [7:0]  write_data,
    input  logic        i2c_ready,
    output logic        i2c_enable,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    output logic [7:0]  i2c_data,
    input  logic        clear_err,
    output logic        busy,
    output logic        error,
    output logic [15:0] byte_count
);

    // Last timer value allowed in START / WAIT_DONE before giving up.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    state_t               state;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer;
    logic                 timeout_hit;
    logic                 done_hit;
    logic                 echo_fire;

    assign i2c_addr  = SLAVE_ADDR;
    assign i2c_rw    = I2C_WRITE;
    assign echo_fire = (state == ST_ECHO) && !tx_full;

    // State register; reset forces IDLE immediately, abandoning any byte in flight.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a master response in the same cycle as the timeout wins.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        done_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_empty && i2c_ready) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                state_next = ST_START;
            end
            ST_START: begin
                if (!i2c_ready) begin
                    state_next = ST_WAIT_DONE;
                end else if (timer >= TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_ready) begin
                    done_hit   = 1'b1;
                    state_next = ECHO_EN ? ST_ECHO : ST_IDLE;
                end else if (timer >= TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_ECHO: begin
                // TX back-pressure is legitimate, so no watchdog here.
                if (!tx_full) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Watchdog timer: restarts on LATCH and on the START->WAIT_DONE handoff, saturates.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (state == ST_LATCH ||
                     (state == ST_START && state_next == ST_WAIT_DONE)) begin
            timer <= '0;
        end else if ((state == ST_START || state == ST_WAIT_DONE) && timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    // Handshake outputs, registered from the upcoming state so they align with it.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            read_uart  <= 1'b0;
            i2c_enable <= 1'b0;
            i2c_data   <= 8'h00;
            write_uart <= 1'b0;
            write_data <= 8'h00;
            busy       <= 1'b0;
        end else begin
            read_uart  <= (state == ST_IDLE) && (state_next == ST_LATCH);
            i2c_enable <= (state_next == ST_START);
            busy       <= (state_next != ST_IDLE);
            write_uart <= echo_fire;
            // Capture the FIFO head alongside the pop so it is valid from LATCH on.
            if (state == ST_IDLE && state_next == ST_LATCH) begin
                i2c_data <= rx_data;
            end
            if (echo_fire) begin
                write_data <= i2c_data;
            end
        end
    end

    // Status: completed-transfer counter and sticky timeout flag (set beats clear).
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            byte_count <= 16'h0000;
            error      <= 1'b0;
        end else begin
            if (done_hit) begin
                byte_count <= byte_count + 16'd1;
            end
            if (timeout_hit) begin
                error <= 1'b1;
            end else if (clear_err) begin
                error <= 1'b0;
            end
        end
    end

endmodule
